dmem_arbiter: RTL and testbench

//   Two-port arbiter that shares the single-port data RAM between the CPU data port (requester 0)
//   and a DMA/loader engine (requester 1). Performs at most one access per cycle and drives the RAM
//   we/adr/din. Fairness is round-robin; an optional lock gives atomic bursts. Reads return one

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_arbiter_if.sv | 56 +++++
 rtl/rr_arb2.sv | 22 ++
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and state encodings for the data-memory arbiter
// Contents:
//   DMEM_DEPTH / DMEM_WIDTH / DMEM_BITS  default RAM geometry
//   state_t, ST_IDLE / ST_OWN0 / ST_OWN1 arbiter FSM encodings
//   own_state()                          maps a winning requester to its lock-owner state
package dmem_pkg;

    localparam int DMEM_DEPTH = 128;
    localparam int DMEM_WIDTH = 32;
    localparam int DMEM_BITS  = 32;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    function automatic state_t own_state(input logic sel1);
        return sel1 ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and RAM bus bundle for the data-memory arbiter
// Signals:
//   req/we/adr/wd/lock 0,1   requester side, driven by the CPU and DMA engine
//   gnt/rvalid/rdata/err 0,1 arbiter responses
//   mem_we/mem_adr/mem_din   arbiter to RAM
//   mem_dout                 RAM to arbiter, combinational read of mem_adr
// Modports:
//   master  requesters plus attached RAM
//   slave   the arbiter
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int BITS  = DMEM_BITS,
    parameter int WIDTH = DMEM_WIDTH
) ();

    logic             req0;
    logic             req1;
    logic             we0;
    logic             we1;
    logic             lock0;
    logic             lock1;
    logic [BITS-1:0]  adr0;
    logic [BITS-1:0]  adr1;
    logic [WIDTH-1:0] wd0;
    logic [WIDTH-1:0] wd1;

    logic             gnt0;
    logic             gnt1;
    logic             rvalid0;
    logic             rvalid1;
    logic [WIDTH-1:0] rdata0;
    logic [WIDTH-1:0] rdata1;
    logic             err0;
    logic             err1;

    logic             mem_we;
    logic [BITS-1:0]  mem_adr;
    logic [WIDTH-1:0] mem_din;
    logic [WIDTH-1:0] mem_dout;

    modport master (
        output req0, req1, we0, we1, lock0, lock1, adr0, adr1, wd0, wd1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        input  mem_we, mem_adr, mem_din,
        output mem_dout
    );

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, adr0, adr1, wd0, wd1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        output mem_we, mem_adr, mem_din,
        input  mem_dout
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick, combinational one-hot grant
// Ports:
//   req   in  2  request vector, bit n = requester n
//   last  in  1  requester that won the previous grant
//   gnt   out 2  one-hot grant (all zero when nothing requests)
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one single-port data RAM between CPU (0) and DMA (1)
// Ports:
//   clk    in   single clock, posedge
//   reset  in   synchronous, active-high
//   bus    slave modport of dmem_arbiter_if: requester handshakes, responses, RAM bus
// Behaviour summary:
//   one access per cycle, round-robin on ties, lock keeps the grant with its owner,
//   reads return one cycle after grant, misaligned/out-of-range accesses raise err.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int BITS  = DMEM_BITS,
    parameter int WIDTH = DMEM_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam logic [BITS-3:0] DEPTH_W = (BITS-2)'(DEPTH);

    state_t           state;
    state_t           state_nxt;
    logic             last;
    logic [1:0]       rr_gnt;
    logic [1:0]       pick;
    logic             any;

    logic [BITS-1:0]  adr_sel;
    logic [WIDTH-1:0] wd_sel;
    logic             we_sel;
    logic             lock_sel;
    logic             bad_sel;
    logic             rd_ok;

    function automatic logic is_bad(input logic [BITS-1:0] adr);
        return (adr[1:0] != 2'b00) || (adr[BITS-1:2] >= DEPTH_W);
    endfunction

    rr_arb2 u_rr (
        .req  ({bus.req1, bus.req0}),
        .last (last),
        .gnt  (rr_gnt)
    );

    // Grant selection. While a lock owner exists the other side is not even
    // considered; if the owner stops requesting, this cycle goes idle.
    always_comb begin
        pick = 2'b00;
        if (!reset) begin
            case (state)
                ST_IDLE: pick = rr_gnt;
                ST_OWN0: pick = {1'b0, bus.req0};
                ST_OWN1: pick = {bus.req1, 1'b0};
                default: pick = 2'b00;
            endcase
        end
    end

    assign any = |pick;

    always_comb begin
        adr_sel  = bus.adr0;
        wd_sel   = bus.wd0;
        we_sel   = bus.we0;
        lock_sel = bus.lock0;
        if (pick[1]) begin
            adr_sel  = bus.adr1;
            wd_sel   = bus.wd1;
            we_sel   = bus.we1;
            lock_sel = bus.lock1;
        end
    end

    assign bad_sel = is_bad(adr_sel);
    assign rd_ok   = any & ~we_sel & ~bad_sel;

    assign bus.gnt0    = pick[0];
    assign bus.gnt1    = pick[1];
    assign bus.mem_we  = any & we_sel & ~bad_sel;
    assign bus.mem_adr = any ? adr_sel : '0;
    assign bus.mem_din = any ? wd_sel  : '0;

    // Ownership is only taken from IDLE; a lock raised by the non-owner is
    // ignored until the owner releases and the FSM passes through IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (any && lock_sel) begin
                    state_nxt = own_state(pick[1]);
                end
            end
            ST_OWN0: begin
                if (!(bus.req0 && bus.lock0)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (!(bus.req1 && bus.lock1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            last        <= 1'b1;
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            bus.rdata0  <= '0;
            bus.rdata1  <= '0;
            bus.err0    <= 1'b0;
            bus.err1    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (any) begin
                last <= pick[1];
            end
            bus.rvalid0 <= pick[0] & rd_ok;
            bus.rvalid1 <= pick[1] & rd_ok;
            bus.rdata0  <= (pick[0] & rd_ok) ? bus.mem_dout : '0;
            bus.rdata1  <= (pick[1] & rd_ok) ? bus.mem_dout : '0;
            bus.err0    <= pick[0] & bad_sel;
            bus.err1    <= pick[1] & bad_sel;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized checks of dmem_arbiter against a reference model
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int DEPTH = 128;
    localparam int BITS  = 32;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.BITS(BITS), .WIDTH(WIDTH)) bus ();

    dmem_arbiter #(.DEPTH(DEPTH), .BITS(BITS), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Attached RAM: combinational read, write at posedge.
    logic [31:0] ram [DEPTH];
    always_comb begin
        bus.mem_dout = (bus.mem_adr[31:9] == '0) ? ram[bus.mem_adr[8:2]] : 32'h0;
    end
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_adr[8:2]] <= bus.mem_din;
    end

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    int          owner;
    int          last_w;
    logic        exp_rv [2];
    logic        exp_err [2];
    logic [31:0] exp_rd [2];

    // Requester stimulus
    logic        r [2];
    logic        w [2];
    logic        l [2];
    logic [31:0] a [2];
    logic [31:0] d [2];

    int   g;
    logic sg0, sg1, swe;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit bad_adr(input logic [31:0] adr);
        return (adr[1:0] != 2'b00) || ((adr >> 2) >= 32'(DEPTH));
    endfunction

    task automatic drive();
        bus.req0 = r[0]; bus.we0 = w[0]; bus.lock0 = l[0]; bus.adr0 = a[0]; bus.wd0 = d[0];
        bus.req1 = r[1]; bus.we1 = w[1]; bus.lock1 = l[1]; bus.adr1 = a[1]; bus.wd1 = d[1];
    endtask

    task automatic idle_all();
        for (int n = 0; n < 2; n++) begin
            r[n] = 1'b0; w[n] = 1'b0; l[n] = 1'b0; a[n] = 32'h0; d[n] = 32'h0;
        end
    endtask

    task automatic set_req(input int n, input logic we, input logic [31:0] adr,
                           input logic [31:0] data, input logic lk);
        r[n] = 1'b1; w[n] = we; a[n] = adr; d[n] = data; l[n] = lk;
    endtask

    // One clock: apply inputs, check combinational and registered outputs
    // against the model, then advance the model across the posedge.
    task automatic step();
        int          gm;
        logic        e_we;
        logic [31:0] e_adr, e_din;
        drive();
        #1;
        gm = -1;
        if (!reset) begin
            if (owner < 0) begin
                if (r[0] && r[1]) gm = (last_w == 1) ? 0 : 1;
                else if (r[0])    gm = 0;
                else if (r[1])    gm = 1;
            end else if (r[owner]) begin
                gm = owner;
            end
        end
        e_we = 1'b0; e_adr = 32'h0; e_din = 32'h0;
        if (gm >= 0) begin
            e_adr = a[gm];
            e_din = d[gm];
            e_we  = w[gm] && !bad_adr(a[gm]);
        end
        sg0 = bus.gnt0; sg1 = bus.gnt1; swe = bus.mem_we;
        check("gnt0",    bus.gnt0,    gm == 0);
        check("gnt1",    bus.gnt1,    gm == 1);
        check("mem_we",  bus.mem_we,  e_we);
        check("mem_adr", bus.mem_adr, e_adr);
        check("mem_din", bus.mem_din, e_din);
        check("rvalid0", bus.rvalid0, exp_rv[0]);
        check("rvalid1", bus.rvalid1, exp_rv[1]);
        check("err0",    bus.err0,    exp_err[0]);
        check("err1",    bus.err1,    exp_err[1]);
        check("rdata0",  bus.rdata0,  exp_rd[0]);
        check("rdata1",  bus.rdata1,  exp_rd[1]);
        g = gm;
        @(posedge clk);
        if (reset) begin
            owner = -1;
            last_w = 1;
            for (int n = 0; n < 2; n++) begin
                exp_rv[n] = 1'b0; exp_err[n] = 1'b0; exp_rd[n] = 32'h0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                exp_rv[n]  = (gm == n) && !w[n] && !bad_adr(a[n]);
                exp_err[n] = (gm == n) && bad_adr(a[n]);
                exp_rd[n]  = exp_rv[n] ? ref_mem[a[n][8:2]] : 32'h0;
            end
            if (gm >= 0 && w[gm] && !bad_adr(a[gm])) ref_mem[a[gm][8:2]] = d[gm];
            if (owner < 0) owner = (gm >= 0 && l[gm]) ? gm : -1;
            else           owner = (r[owner] && l[owner]) ? owner : -1;
            if (gm >= 0) last_w = gm;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic new_req(input int n);
        int k;
        r[n] = ($urandom_range(0, 99) < 60);
        w[n] = $urandom_range(0, 1) == 1;
        k = $urandom_range(0, 19);
        if (k < 17)       a[n] = 32'(k) << 2;
        else if (k == 17) a[n] = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        else if (k == 18) a[n] = 32'h200 + (32'($urandom_range(0, 63)) << 2);
        else              a[n] = 32'h1FC;
        d[n] = $urandom;
        l[n] = ($urandom_range(0, 3) == 0);
    endtask

    logic [31:0] saved;

    initial begin
        reset = 1'b1;
        idle_all();
        drive();
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        ram[2]     = 32'hDEADBEEF;
        ref_mem[2] = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        owner = -1;
        last_w = 1;
        for (int n = 0; n < 2; n++) begin
            exp_rv[n] = 1'b0; exp_err[n] = 1'b0; exp_rd[n] = 32'h0;
        end

        // 1: single read after reset
        do_reset();
        set_req(0, 1'b0, 32'h8, 32'h0, 1'b0);
        step();
        check("t1_gnt0", sg0, 1'b1);
        idle_all();
        check("t1_rvalid0", bus.rvalid0, 1'b1);
        check("t1_rdata0", bus.rdata0, 32'hDEADBEEF);

        // 2: write by 0 and read by 1 of the same word in the same cycle
        do_reset();
        set_req(0, 1'b1, 32'h10, 32'h1234, 1'b0);
        set_req(1, 1'b0, 32'h10, 32'h0, 1'b0);
        step();
        check("t2_gnt0_first", sg0, 1'b1);
        check("t2_gnt1_wait", sg1, 1'b0);
        r[0] = 1'b0;
        step();
        check("t2_gnt1_next", sg1, 1'b1);
        r[1] = 1'b0;
        check("t2_rvalid1", bus.rvalid1, 1'b1);
        check("t2_rdata1", bus.rdata1, 32'h1234);

        // 3: both held, no locks -> alternate
        do_reset();
        set_req(0, 1'b0, 32'hC, 32'h0, 1'b0);
        set_req(1, 1'b0, 32'h14, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_gnt0", sg0, (i % 2) == 0);
            check("t3_gnt1", sg1, (i % 2) == 1);
        end
        idle_all();

        // 4: locked burst of three writes by 1 while 0 waits
        do_reset();
        set_req(1, 1'b1, 32'h20, 32'hA0A0_0001, 1'b1);
        step();
        check("t4_gnt1_a", sg1, 1'b1);
        set_req(0, 1'b0, 32'h8, 32'h0, 1'b0);
        set_req(1, 1'b1, 32'h24, 32'hA0A0_0002, 1'b1);
        step();
        check("t4_gnt1_b", sg1, 1'b1);
        check("t4_gnt0_b", sg0, 1'b0);
        set_req(1, 1'b1, 32'h28, 32'hA0A0_0003, 1'b0);
        step();
        check("t4_gnt1_c", sg1, 1'b1);
        check("t4_gnt0_c", sg0, 1'b0);
        r[1] = 1'b0;
        step();
        check("t4_gnt0_after", sg0, 1'b1);
        idle_all();
        check("t4_ram8", ram[8], 32'hA0A0_0001);
        check("t4_ram9", ram[9], 32'hA0A0_0002);
        check("t4_ram10", ram[10], 32'hA0A0_0003);

        // 5: misaligned and out-of-range accesses
        do_reset();
        saved = ram[1];
        set_req(0, 1'b0, 32'h6, 32'h0, 1'b0);
        step();
        check("t5_gnt0_mis", sg0, 1'b1);
        check("t5_err0_mis", bus.err0, 1'b1);
        check("t5_rvalid0_mis", bus.rvalid0, 1'b0);
        set_req(0, 1'b0, 32'h200, 32'h0, 1'b0);
        step();
        check("t5_err0_oor", bus.err0, 1'b1);
        check("t5_rvalid0_oor", bus.rvalid0, 1'b0);
        set_req(0, 1'b1, 32'h6, 32'h5555_AAAA, 1'b0);
        step();
        check("t5_mem_we", swe, 1'b0);
        check("t5_err0_wr", bus.err0, 1'b1);
        idle_all();
        step();
        check("t5_err0_drop", bus.err0, 1'b0);
        check("t5_ram_kept", ram[1], saved);

        // 6: reset during a locked burst with a read outstanding
        do_reset();
        set_req(1, 1'b0, 32'h8, 32'h0, 1'b1);
        step();
        check("t6_gnt1", sg1, 1'b1);
        set_req(0, 1'b0, 32'hC, 32'h0, 1'b0);
        set_req(1, 1'b0, 32'h10, 32'h0, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_rvalid1", bus.rvalid1, 1'b0);
        check("t6_err0", bus.err0, 1'b0);
        check("t6_err1", bus.err1, 1'b0);
        step();
        check("t6_gnt0_first", sg0, 1'b1);
        check("t6_gnt1_wait", sg1, 1'b0);
        idle_all();

        // Randomized traffic; a request is held until granted
        do_reset();
        new_req(0);
        new_req(1);
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            step();
            for (int n = 0; n < 2; n++) begin
                if (g == n || !r[n]) new_req(n);
            end
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
